vc_test_rand_delay_sink_checker: RTL
====================================

VC_TEST_RAND_DELAY_SINK_CHECKER -- requirements
Module: vc_TestRandDelaySinkChecker

Interface
REQ-001 Parameter p_msg_nbits, default 1: width of checked messages.
REQ-002 Parameter p_num_msgs, default 1024: depth of the expected-message store.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port max_delay  input  32  upper bound of random stall cycles per message.
REQ-006 Port load_val  input  1  append load_msg to the expected store this cycle.
REQ-007 Port load_msg  input  p_msg_nbits  expected message being appended.
REQ-008 Port val  input  1  upstream message valid.
REQ-009 Port rdy  output  1  sink ready; handshake = val && rdy at a rising edge.
REQ-010 Port msg  input  p_msg_nbits  upstream message.
REQ-011 Port done  output  1  high once every loaded message has been received.
REQ-012 Port num_failed  output  32  count of mismatched messages.
REQ-013 Port last_fail_idx  output  32  index of most recent mismatched message.
REQ-014 Port err  output  1  one-cycle pulse on the cycle after a mismatching handshake.

Function
REQ-015 The block SHALL hold an expected-message array of p_num_msgs entries, a load count num_loaded, a receive index idx, a 32-bit stall counter cnt, and a 16-bit LFSR.
REQ-016 load_val SHALL write load_msg to entry num_loaded and increment num_loaded when num_loaded < p_num_msgs; load_val SHALL be ignored when the store is full.
REQ-017 The LFSR SHALL advance every cycle, polynomial x^16+x^14+x^13+x^11+1, never zero.
REQ-018 A delay draw SHALL equal 0 when max_delay == 0, else LFSR value modulo (max_delay+1), using max_delay sampled in the drawing cycle.
REQ-019 The FSM SHALL have states WAIT, READY, DONE; rdy SHALL be 1 only in READY, done 1 only in DONE.
REQ-020 WAIT: if cnt != 0, decrement cnt; else if idx < num_loaded go to READY; else remain.
REQ-021 READY without handshake: remain; rdy SHALL stay high until a handshake occurs (no retraction).
REQ-022 READY with handshake: compare msg to entry idx, increment idx, draw a delay d; next state DONE if idx+1 == num_loaded, else READY if d == 0 and idx+1 < num_loaded, else WAIT with cnt = d-1.
REQ-023 With max_delay == 0 and data available, the block SHALL accept one message per cycle.
REQ-024 On mismatch, num_failed SHALL increment (saturating at 32'hFFFFFFFF), last_fail_idx SHALL take the pre-increment idx, and err SHALL pulse high for exactly the following cycle.
REQ-025 DONE SHALL be terminal until reset; val in DONE SHALL be ignored and no counters SHALL change.
REQ-026 A load arriving in the same cycle as a handshake SHALL be counted before the DONE decision of REQ-022 (idx+1 compared against the post-load num_loaded).
REQ-027 The block SHALL never assert rdy while idx >= num_loaded.
REQ-028 Comparison SHALL be full-width bitwise equality on p_msg_nbits bits; no X-masking.

Reset
REQ-029 Asserting reset SHALL immediately force state WAIT, cnt 0, idx 0, num_loaded 0, num_failed 0, last_fail_idx 0, err 0, rdy 0, done 0, LFSR 16'hACE1.
REQ-030 Reset mid-operation SHALL abandon any pending stall or handshake; stored array contents need not be cleared but SHALL be unreachable until reloaded.
REQ-031 The first rising edge after reset deassertion SHALL be treated as WAIT with cnt 0.

Verification
REQ-032 Load 4 msgs {1,2,3,4}, max_delay 0, source val constant high with 1..4 -> rdy high 4 consecutive cycles, done next cycle, num_failed 0.
REQ-033 Same load, source sends {1,9,3,4} -> err pulses once, num_failed 1, last_fail_idx 1, done asserted.
REQ-034 Load 8 msgs, max_delay 5, source always valid -> each gap between handshakes 0..5 stall cycles, all 8 accepted in order, done high, num_failed 0.
REQ-035 num_loaded 0 with val high for 20 cycles -> rdy stays 0, done stays 0.
REQ-036 Assert reset after 2 of 4 handshakes, reload 2 msgs, resend -> counters restart from 0, done after 2 handshakes.
REQ-037 Load p_num_msgs+1 entries -> last load ignored, num_loaded == p_num_msgs, done only after p_num_msgs handshakes.

Source files
------------

// File: rtl/vc_test_rand_delay_sink_checker.sv
// Test sink: holds a loaded list of expected messages, accepts upstream messages
// after LFSR-driven random stalls, and counts/flags any that differ from the list.
module vc_test_rand_delay_sink_checker #(
  parameter int p_msg_nbits = 1,
  parameter int p_num_msgs  = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            max_delay,
  input  logic                   load_val,
  input  logic [p_msg_nbits-1:0] load_msg,
  input  logic                   val,
  output logic                   rdy,
  input  logic [p_msg_nbits-1:0] msg,
  output logic                   done,
  output logic [31:0]            num_failed,
  output logic [31:0]            last_fail_idx,
  output logic                   err
);

  localparam int          AW        = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
  localparam logic [31:0] NUM_MSGS  = 32'(p_num_msgs);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {S_WAIT, S_READY, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [31:0]            cnt, cnt_nxt;
  logic [31:0]            idx, idx_nxt;
  logic [31:0]            num_loaded, num_loaded_nxt;
  logic [31:0]            num_failed_nxt, last_fail_idx_nxt;
  logic [15:0]            lfsr, lfsr_nxt;
  logic                   err_nxt;
  logic                   load_en, hshk, mismatch;
  logic [31:0]            draw;
  logic [p_msg_nbits-1:0] exp_msg;
  logic [p_msg_nbits-1:0] mem [p_num_msgs];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // max_delay of all ones would overflow max_delay+1; any 16-bit value is below it anyway.
  function automatic logic [31:0] delay_draw(input logic [15:0] r, input logic [31:0] maxd);
    logic [31:0] d;
    if (maxd == 32'd0)
      d = 32'd0;
    else if (maxd == 32'hFFFF_FFFF)
      d = {16'b0, r};
    else
      d = {16'b0, r} % (maxd + 32'd1);
    return d;
  endfunction

  // Expected-message store: data only, never reset.
  always_ff @(posedge clk) begin
    if (load_en)
      mem[num_loaded[AW-1:0]] <= load_msg;
  end

  assign exp_msg  = mem[idx[AW-1:0]];
  assign load_en  = load_val && (num_loaded < NUM_MSGS) && (state != S_DONE);
  assign hshk     = (state == S_READY) && val;
  assign mismatch = (msg != exp_msg);
  assign draw     = delay_draw(lfsr, max_delay);
  assign rdy      = (state == S_READY);
  assign done     = (state == S_DONE);

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    idx_nxt           = idx;
    num_loaded_nxt    = num_loaded + {31'b0, load_en};
    num_failed_nxt    = num_failed;
    last_fail_idx_nxt = last_fail_idx;
    err_nxt           = 1'b0;
    lfsr_nxt          = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    case (state)
      S_WAIT: begin
        if (cnt != 32'd0)
          cnt_nxt = cnt - 32'd1;
        else if (idx < num_loaded)
          state_nxt = S_READY;
      end
      S_READY: begin
        if (hshk) begin
          idx_nxt = idx + 32'd1;
          if (mismatch) begin
            num_failed_nxt    = sat_inc(num_failed);
            last_fail_idx_nxt = idx;
            err_nxt           = 1'b1;
          end
          // A same-cycle load counts toward the completion decision.
          if (idx_nxt == num_loaded_nxt)
            state_nxt = S_DONE;
          else if (draw == 32'd0)
            state_nxt = S_READY;
          else begin
            state_nxt = S_WAIT;
            cnt_nxt   = draw - 32'd1;
          end
        end
      end
      S_DONE: ;
      default: state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_WAIT;
      cnt           <= 32'd0;
      idx           <= 32'd0;
      num_loaded    <= 32'd0;
      num_failed    <= 32'd0;
      last_fail_idx <= 32'd0;
      err           <= 1'b0;
      lfsr          <= LFSR_SEED;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      idx           <= idx_nxt;
      num_loaded    <= num_loaded_nxt;
      num_failed    <= num_failed_nxt;
      last_fail_idx <= last_fail_idx_nxt;
      err           <= err_nxt;
      lfsr          <= lfsr_nxt;
    end
  end

endmodule
